// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: default memory geometry,
// sequencer state encodings and port identifiers.
// Imported by dmem_arbiter and rr_arb2.
package dmem_arbiter_pkg;

    localparam int DMEM_MEM_WIDTH = 32;
    localparam int DMEM_MEM_DEPTH = 256;

    typedef logic [2:0] dmem_state_t;

    localparam logic [2:0] DMEM_ST_IDLE   = 3'd0;
    localparam logic [2:0] DMEM_ST_RD     = 3'd1;
    localparam logic [2:0] DMEM_ST_RDATA  = 3'd2;
    localparam logic [2:0] DMEM_ST_WR     = 3'd3;
    localparam logic [2:0] DMEM_ST_RMW_RD = 3'd4;
    localparam logic [2:0] DMEM_ST_RMW_WR = 3'd5;

    localparam logic DMEM_PORT_CORE = 1'b0;
    localparam logic DMEM_PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// port that did not win last time is chosen.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Ports: req[1:0] requests, last = index of previous winner, gnt[1:0] one-hot pick.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == DMEM_PORT_DBG));
        gnt[1] = req[1] & (~req[0] | (last == DMEM_PORT_CORE));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer in front of a single-port data memory;
// port 0 = core LSU, port 1 = debug/DMA. Partial stores become read-modify-write.
// Latency from grant cycle T: load rvalid T+2, full store we T+1, partial store we T+2.
// Backpressure: a requester holds req until its one-cycle gnt; grants only issue in IDLE.
// Ports: pN_* request/response per port, mem_* to the memory, busy = sequencer active.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_WIDTH = DMEM_MEM_WIDTH,
    parameter int MEM_DEPTH = DMEM_MEM_DEPTH,
    localparam int ADDR_W   = $clog2(MEM_DEPTH),
    localparam int BE_W     = MEM_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_W-1:0]    p0_addr,
    input  logic [MEM_WIDTH-1:0] p0_wdata,
    input  logic [BE_W-1:0]      p0_be,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [MEM_WIDTH-1:0] p0_rdata,

    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_W-1:0]    p1_addr,
    input  logic [MEM_WIDTH-1:0] p1_wdata,
    input  logic [BE_W-1:0]      p1_be,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [MEM_WIDTH-1:0] p1_rdata,

    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wdata,
    input  logic [MEM_WIDTH-1:0] mem_rdata,

    output logic                 busy
);

    dmem_state_t          state;
    dmem_state_t          state_nxt;
    logic                 last_gnt;

    logic                 lat_we;
    logic                 lat_port;
    logic [ADDR_W-1:0]    lat_addr;
    logic [MEM_WIDTH-1:0] lat_wdata;
    logic [BE_W-1:0]      lat_be;

    logic [MEM_WIDTH-1:0] p0_rdata_q;
    logic [MEM_WIDTH-1:0] p1_rdata_q;
    logic [MEM_WIDTH-1:0] merged;

    logic [1:0]           arb_gnt;
    logic                 idle;
    logic                 any_gnt;
    logic                 sel_port;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [MEM_WIDTH-1:0] sel_wdata;
    logic [BE_W-1:0]      sel_be;

    rr_arb2 u_rr_arb2 (
        .req  ({p1_req, p0_req}),
        .last (last_gnt),
        .gnt  (arb_gnt)
    );

    assign idle    = (state == DMEM_ST_IDLE);
    assign any_gnt = idle & (|arb_gnt);

    // Fields of whichever port the arbiter picked this cycle.
    assign sel_port  = arb_gnt[1];
    assign sel_we    = sel_port ? p1_we    : p0_we;
    assign sel_addr  = sel_port ? p1_addr  : p0_addr;
    assign sel_wdata = sel_port ? p1_wdata : p0_wdata;
    assign sel_be    = sel_port ? p1_be    : p0_be;

    // Grants are combinational in IDLE; masked during reset so every output reads 0.
    assign p0_gnt = idle & arb_gnt[0] & ~rst;
    assign p1_gnt = idle & arb_gnt[1] & ~rst;

    always_comb begin
        state_nxt = state;
        case (state)
            DMEM_ST_IDLE: begin
                if (any_gnt) begin
                    if (!sel_we)
                        state_nxt = DMEM_ST_RD;
                    else if (&sel_be)
                        state_nxt = DMEM_ST_WR;
                    else if (|sel_be)
                        state_nxt = DMEM_ST_RMW_RD;
                    else
                        state_nxt = DMEM_ST_IDLE;  // empty store: acknowledged, no access
                end
            end
            DMEM_ST_RD:     state_nxt = DMEM_ST_RDATA;
            DMEM_ST_RDATA:  state_nxt = DMEM_ST_IDLE;
            DMEM_ST_WR:     state_nxt = DMEM_ST_IDLE;
            DMEM_ST_RMW_RD: state_nxt = DMEM_ST_RMW_WR;
            DMEM_ST_RMW_WR: state_nxt = DMEM_ST_IDLE;
            default:        state_nxt = DMEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DMEM_ST_IDLE;
            last_gnt  <= DMEM_PORT_DBG;  // so port 0 wins the first tie
            lat_we    <= 1'b0;
            lat_port  <= DMEM_PORT_CORE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state <= state_nxt;
            if (any_gnt) begin
                last_gnt  <= sel_port;
                lat_we    <= sel_we;
                lat_port  <= sel_port;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_be    <= sel_be;
            end
        end
    end

    // Read data arrives the cycle after mem_re; it is forwarded straight out in
    // RDATA and captured so the port keeps showing it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else if (state == DMEM_ST_RDATA) begin
            if (lat_port == DMEM_PORT_CORE)
                p0_rdata_q <= mem_rdata;
            else
                p1_rdata_q <= mem_rdata;
        end
    end

    assign p0_rvalid = (state == DMEM_ST_RDATA) & (lat_port == DMEM_PORT_CORE);
    assign p1_rvalid = (state == DMEM_ST_RDATA) & (lat_port == DMEM_PORT_DBG);
    assign p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_q;
    assign p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_q;

    // Byte merge for the write half of a read-modify-write.
    for (genvar i = 0; i < BE_W; i++) begin : g_merge
        assign merged[i*8 +: 8] = lat_be[i] ? lat_wdata[i*8 +: 8] : mem_rdata[i*8 +: 8];
    end

    // Strobes decode from state only, so an async reset kills them at once.
    assign mem_re    = (state == DMEM_ST_RD) | (state == DMEM_ST_RMW_RD);
    assign mem_we    = (state == DMEM_ST_WR) | (state == DMEM_ST_RMW_WR);
    assign mem_addr  = lat_addr;
    assign mem_wdata = (state == DMEM_ST_RMW_WR) ? merged : lat_wdata;
    assign busy      = ~idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory
// (registered read, valid the cycle after re). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int D  = 256;
    localparam int AW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [W-1:0]  p0_wdata, p0_rdata;
    logic [BW-1:0] p0_be;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [W-1:0]  p1_wdata, p1_rdata;
    logic [BW-1:0] p1_be;
    logic          mem_we, mem_re, busy;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0]  mem [D];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [W-1:0]  pl_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en)  mem[pl_addr] <= pl_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    dmem_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_be     (p0_be),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_be     (p1_be),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The memory must never see a read and a write in the same cycle.
    always @(negedge clk) chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic we, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input logic [BW-1:0] be);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
        end
    endtask

    task automatic clr_req(input int port);
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_p0_gnt"},    32'(p0_gnt),    32'd0);
        chk({tag, "_p1_gnt"},    32'(p1_gnt),    32'd0);
        chk({tag, "_p0_rvalid"}, 32'(p0_rvalid), 32'd0);
        chk({tag, "_p1_rvalid"}, 32'(p1_rvalid), 32'd0);
        chk({tag, "_p0_rdata"},  p0_rdata,       32'd0);
        chk({tag, "_p1_rdata"},  p1_rdata,       32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_re"},    32'(mem_re),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Single-port load with bounded waits for grant and read data.
    task automatic do_load(input int port, input logic [AW-1:0] a,
                           input logic [W-1:0] exp, input string tag);
        logic seen;
        set_req(port, 1'b0, a, 32'h0, 4'h0);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = (port == 0) ? p0_gnt : p1_gnt;
            step();
        end
        clr_req(port);
        chk({tag, "_gnt_seen"}, 32'(seen), 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = (port == 0) ? p0_rvalid : p1_rvalid;
            if (seen) chk({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp);
            step();
        end
        chk({tag, "_rvalid_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ng;
        int prev;
        logic exp_port;

        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;

        preload(8'd5, 32'hDEADBEEF);
        preload(8'd7, 32'hAABBCCDD);

        // 1: p0 load of address 5
        set_req(0, 1'b0, 8'd5, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_p0_gnt_T", 32'(p0_gnt), 32'd1);
        chk("t1_p1_gnt_T", 32'(p1_gnt), 32'd0);
        chk("t1_busy_T",   32'(busy),   32'd0);
        step(); clr_req(0);
        @(negedge clk);
        chk("t1_mem_re_T1",   32'(mem_re),   32'd1);
        chk("t1_mem_we_T1",   32'(mem_we),   32'd0);
        chk("t1_mem_addr_T1", 32'(mem_addr), 32'd5);
        chk("t1_busy_T1",     32'(busy),     32'd1);
        chk("t1_p0_gnt_T1",   32'(p0_gnt),   32'd0);
        step();
        @(negedge clk);
        chk("t1_p0_rvalid_T2", 32'(p0_rvalid), 32'd1);
        chk("t1_p0_rdata_T2",  p0_rdata,       32'hDEADBEEF);
        chk("t1_p1_rvalid_T2", 32'(p1_rvalid), 32'd0);
        chk("t1_p1_rdata_T2",  p1_rdata,       32'd0);
        step();
        @(negedge clk);
        chk("t1_p0_rvalid_T3", 32'(p0_rvalid), 32'd0);
        chk("t1_p0_rdata_hold", p0_rdata,      32'hDEADBEEF);
        chk("t1_busy_T3",      32'(busy),      32'd0);
        step();

        // 2: p1 full-word store to address 3, then read it back
        set_req(1, 1'b1, 8'd3, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("t2_p1_gnt_T", 32'(p1_gnt), 32'd1);
        chk("t2_p0_gnt_T", 32'(p0_gnt), 32'd0);
        step(); clr_req(1);
        @(negedge clk);
        chk("t2_mem_we_T1",    32'(mem_we),   32'd1);
        chk("t2_mem_re_T1",    32'(mem_re),   32'd0);
        chk("t2_mem_addr_T1",  32'(mem_addr), 32'd3);
        chk("t2_mem_wdata_T1", mem_wdata,     32'h12345678);
        step();
        @(negedge clk);
        chk("t2_mem_we_T2", 32'(mem_we), 32'd0);
        chk("t2_busy_T2",   32'(busy),   32'd0);
        step();
        do_load(0, 8'd3, 32'h12345678, "t2_readback");

        // 3: p0 partial store to address 7 (byte 1 only)
        set_req(0, 1'b1, 8'd7, 32'h00001100, 4'b0010);
        @(negedge clk);
        chk("t3_p0_gnt_T", 32'(p0_gnt), 32'd1);
        step(); clr_req(0);
        @(negedge clk);
        chk("t3_mem_re_T1",   32'(mem_re),   32'd1);
        chk("t3_mem_we_T1",   32'(mem_we),   32'd0);
        chk("t3_mem_addr_T1", 32'(mem_addr), 32'd7);
        step();
        @(negedge clk);
        chk("t3_mem_we_T2",    32'(mem_we),   32'd1);
        chk("t3_mem_re_T2",    32'(mem_re),   32'd0);
        chk("t3_mem_addr_T2",  32'(mem_addr), 32'd7);
        chk("t3_mem_wdata_T2", mem_wdata,     32'hAABB11DD);
        step();
        @(negedge clk);
        chk("t3_busy_T3", 32'(busy), 32'd0);
        chk("t3_mem7",    mem[7],    32'hAABB11DD);
        step();

        // 4: both ports request continuously from reset; expect p0,p1,p0,p1
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b0, 8'd5, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'd3, 32'h0, 4'h0);
        ng = 0; prev = 0; exp_port = 1'b0;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            @(negedge clk);
            if (p0_rvalid) chk("t4_p0_rdata", p0_rdata, 32'hDEADBEEF);
            if (p1_rvalid) chk("t4_p1_rdata", p1_rdata, 32'h12345678);
            if (p0_gnt || p1_gnt) begin
                chk("t4_one_hot", 32'(p0_gnt & p1_gnt), 32'd0);
                chk("t4_order",   32'(p1_gnt),          32'(exp_port));
                if (ng > 0) chk("t4_gap", 32'(cyc - prev), 32'd3);
                prev = cyc;
                exp_port = ~exp_port;
                ng++;
            end
            step();
        end
        clr_req(0); clr_req(1);
        chk("t4_grant_count", 32'(ng), 32'd4);
        repeat (3) step();

        // 5: store with no byte enables is acknowledged but touches nothing
        set_req(0, 1'b1, 8'd9, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        chk("t5_p0_gnt_T", 32'(p0_gnt), 32'd1);
        chk("t5_busy_T",   32'(busy),   32'd0);
        step(); clr_req(0);
        @(negedge clk);
        chk("t5_busy_T1",     32'(busy),     32'd0);
        chk("t5_mem_we_T1",   32'(mem_we),   32'd0);
        chk("t5_mem_re_T1",   32'(mem_re),   32'd0);
        chk("t5_p0_gnt_T1",   32'(p0_gnt),   32'd0);
        chk("t5_mem_addr_T1", 32'(mem_addr), 32'd9);
        step();

        // 6: reset arrives while the partial store is in its read phase
        set_req(0, 1'b1, 8'd7, 32'h000000FF, 4'b0001);
        @(negedge clk);
        chk("t6_p0_gnt_T", 32'(p0_gnt), 32'd1);
        step(); clr_req(0);
        @(negedge clk);
        chk("t6_mem_re_T1", 32'(mem_re), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_abort_mem_re", 32'(mem_re), 32'd0);
        chk("t6_abort_mem_we", 32'(mem_we), 32'd0);
        chk("t6_abort_busy",   32'(busy),   32'd0);
        @(negedge clk);
        check_all_zero("t6_in_reset");
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_we_after", 32'(mem_we), 32'd0);
            chk("t6_idle_after",  32'(busy),   32'd0);
            step();
        end
        chk("t6_mem7_kept", mem[7], 32'hAABB11DD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
